// File: rtl/oct_line_sequencer.sv
// Slow-axis B-scan frame sequencer: steps the galvo DAC, settles, then launches and kills each CCD line (FRAME_REPEAT_EN loops frames until kill).
// Latency: start -> busy/y_dac_valid next cycle; line_start gap+1 cycles after y_dac_valid; line_kill length+2 cycles after line_start.
// Backpressure: none; each line waits indefinitely for a line_finished rising edge before the next one starts.
module oct_line_sequencer #(
    parameter int DAC_W = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             kill,
    input  logic [15:0]      ydata_points_number,
    input  logic [DAC_W-1:0] y_start,
    input  logic [DAC_W-1:0] y_step,
    input  logic [CNT_W-1:0] line_gap_cycles,
    input  logic [CNT_W-1:0] line_length_cycles,
    input  logic             line_finished,
    output logic             line_start,
    output logic             line_kill,
    output logic [DAC_W-1:0] y_dac,
    output logic             y_dac_valid,
    output logic [15:0]      line_index,
    output logic             busy,
    output logic             frame_done,
    output logic             aborted
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETTLE   = 3'd1;
    localparam logic [2:0] S_LAUNCH   = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_WAIT_FIN = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] gap_r;
    logic [CNT_W-1:0] len_r;
    logic [15:0]      n_r;
    logic [DAC_W-1:0] step_r;
`ifdef FRAME_REPEAT_EN
    logic [DAC_W-1:0] ystart_r;
`endif
    logic             abort_r;
    logic             fin_d;
    logic             fin_rise;
    logic             last_line;

    assign fin_rise  = line_finished & ~fin_d;
    assign last_line = (line_index == (n_r - 16'd1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            cnt         <= '0;
            gap_r       <= '0;
            len_r       <= '0;
            n_r         <= '0;
            step_r      <= '0;
`ifdef FRAME_REPEAT_EN
            ystart_r    <= '0;
`endif
            abort_r     <= 1'b0;
            fin_d       <= 1'b0;
            line_start  <= 1'b0;
            line_kill   <= 1'b0;
            y_dac       <= '0;
            y_dac_valid <= 1'b0;
            line_index  <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            fin_d       <= line_finished;
            line_start  <= 1'b0;
            line_kill   <= 1'b0;
            y_dac_valid <= 1'b0;
            frame_done  <= 1'b0;
            aborted     <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Start coincident with kill is rejected outright.
                    if (start && !kill) begin
                        n_r     <= ydata_points_number;
                        step_r  <= y_step;
                        gap_r   <= line_gap_cycles;
                        len_r   <= line_length_cycles;
`ifdef FRAME_REPEAT_EN
                        ystart_r <= y_start;
`endif
                        abort_r <= 1'b0;
                        if (ydata_points_number != 16'd0) begin
                            y_dac       <= y_start;
                            line_index  <= '0;
                            y_dac_valid <= 1'b1;
                            cnt         <= '0;
                            busy        <= 1'b1;
                            state       <= S_SETTLE;
                        end else begin
                            frame_done <= 1'b1;
                        end
                    end
                end

                S_SETTLE: begin
                    if (kill) begin
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else if (cnt == gap_r) begin
                        // Pulse is raised on entry so it is visible during LAUNCH.
                        line_start <= 1'b1;
                        state      <= S_LAUNCH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_LAUNCH: begin
                    if (kill) begin
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (kill || (cnt == len_r)) begin
                        line_kill <= 1'b1;
                        abort_r   <= abort_r | kill;
                        state     <= S_WAIT_FIN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_WAIT_FIN: begin
                    if (fin_rise) begin
                        if (kill || abort_r) begin
                            aborted <= 1'b1;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end else if (last_line) begin
                            frame_done <= 1'b1;
`ifdef FRAME_REPEAT_EN
                            y_dac       <= ystart_r;
                            line_index  <= '0;
                            y_dac_valid <= 1'b1;
                            cnt         <= '0;
                            state       <= S_SETTLE;
`else
                            busy  <= 1'b0;
                            state <= S_IDLE;
`endif
                        end else begin
                            y_dac       <= y_dac + step_r;
                            line_index  <= line_index + 16'd1;
                            y_dac_valid <= 1'b1;
                            cnt         <= '0;
                            state       <= S_SETTLE;
                        end
                    end else if (kill) begin
                        abort_r <= 1'b1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oct_line_sequencer.sv
// Bench for oct_line_sequencer: table of frame configurations plus hand-built kill, reset and repeat sequences.
module tb_oct_line_sequencer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [15:0] ydata_points_number = '0;
    logic [15:0] y_start = '0;
    logic [15:0] y_step = '0;
    logic [31:0] line_gap_cycles = '0;
    logic [31:0] line_length_cycles = '0;
    logic        line_finished = 1'b0;
    logic        line_start;
    logic        line_kill;
    logic [15:0] y_dac;
    logic        y_dac_valid;
    logic [15:0] line_index;
    logic        busy;
    logic        frame_done;
    logic        aborted;

    oct_line_sequencer #(.DAC_W(16), .CNT_W(32)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .start              (start),
        .kill               (kill),
        .ydata_points_number(ydata_points_number),
        .y_start            (y_start),
        .y_step             (y_step),
        .line_gap_cycles    (line_gap_cycles),
        .line_length_cycles (line_length_cycles),
        .line_finished      (line_finished),
        .line_start         (line_start),
        .line_kill          (line_kill),
        .y_dac              (y_dac),
        .y_dac_valid        (y_dac_valid),
        .line_index         (line_index),
        .busy               (busy),
        .frame_done         (frame_done),
        .aborted            (aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dac;
        logic [15:0] idx;
    } exp_t;

    typedef struct {
        int          n;
        logic [15:0] ys;
        logic [15:0] st;
        int          gap;
        int          len;
        logic [15:0] exp_dac;
        logic [15:0] exp_idx;
    } vec_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ls_cnt = 0;
    int   fd_cnt = 0;
    int   ab_cnt = 0;
    int   cyc = 0;
    int   vld_cyc = 0;
    int   ls_cyc = 0;
    int   cur_gap = 0;
    int   cur_len = 0;
    bit   chk_kill = 1'b1;
    bit   fin_auto = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_counts();
        ls_cnt = 0;
        fd_cnt = 0;
        ab_cnt = 0;
    endtask

    task automatic push_lines(input logic [15:0] ys, input logic [15:0] st, input int cnt);
        exp_t        e;
        logic [15:0] d;
        d = ys;
        for (int i = 0; i < cnt; i++) begin
            e.dac = d;
            e.idx = 16'(i);
            exp_q.push_back(e);
            d = d + st;
        end
    endtask

    task automatic setup(input int n, input logic [15:0] ys, input logic [15:0] st,
                         input int gap, input int len);
        ydata_points_number = 16'(n);
        y_start             = ys;
        y_step              = st;
        line_gap_cycles     = 32'(gap);
        line_length_cycles  = 32'(len);
        cur_gap             = gap;
        cur_len             = len;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        check(name, busy, 0);
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every DAC strobe and checks pulse spacing.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (y_dac_valid) begin
                vld_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_y_dac_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("y_dac", y_dac, e.dac);
                    check("line_index", line_index, e.idx);
                end
            end
            if (line_start) begin
                ls_cnt++;
                ls_cyc = cyc;
                check("start_after_valid", cyc - vld_cyc, cur_gap + 1);
            end
            if (line_kill && chk_kill) check("kill_after_start", cyc - ls_cyc, cur_len + 2);
            if (frame_done) fd_cnt++;
            if (aborted) ab_cnt++;
        end
    end

    // CCD generator model: finished rises two cycles after each line_kill.
    initial begin
        forever begin
            @(negedge clk);
            if (fin_auto && line_kill) begin
                @(negedge clk);
                @(negedge clk);
                line_finished = 1'b1;
                repeat (2) @(negedge clk);
                line_finished = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{n: 3, ys: 16'h1000, st: 16'h0100, gap: 4, len: 10, exp_dac: 16'h1200, exp_idx: 16'd2};
        vecs[1] = '{n: 0, ys: 16'h4444, st: 16'h0001, gap: 4, len: 10, exp_dac: 16'h1200, exp_idx: 16'd2};
        vecs[2] = '{n: 2, ys: 16'hFFF0, st: 16'h0020, gap: 0, len: 0,  exp_dac: 16'h0010, exp_idx: 16'd1};
        vecs[3] = '{n: 1, ys: 16'h8000, st: 16'hFFFF, gap: 1, len: 3,  exp_dac: 16'h8000, exp_idx: 16'd0};
        vecs[4] = '{n: 3, ys: 16'h0005, st: 16'hFFFE, gap: 2, len: 1,  exp_dac: 16'h0001, exp_idx: 16'd2};

        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_y_dac", y_dac, 0);
        check("reset_line_index", line_index, 0);
        check("reset_line_start", line_start, 0);
        check("reset_frame_done", frame_done, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

`ifdef FRAME_REPEAT_EN
        // Two full frames, then kill during WAIT_FIN of the third frame's first line.
        setup(2, 16'h0100, 16'h0010, 2, 4);
        clear_counts();
        push_lines(16'h0100, 16'h0010, 2);
        push_lines(16'h0100, 16'h0010, 2);
        push_lines(16'h0100, 16'h0010, 1);
        pulse_start();
        for (int i = 0; i < 3000 && fd_cnt < 2; i++) @(negedge clk);
        check("repeat_frame_done_count", fd_cnt, 2);
        check("repeat_busy_between_frames", busy, 1);
        for (int i = 0; i < 3000 && ls_cnt < 5; i++) @(negedge clk);
        for (int i = 0; i < 3000 && !line_kill; i++) @(negedge clk);
        check("repeat_line_kill_seen", line_kill, 1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("repeat_busy_after_kill", busy, 1);
        wait_idle("repeat_abort_timeout");
        check("repeat_aborted_count", ab_cnt, 1);
        check("repeat_frame_done_final", fd_cnt, 2);
        check("repeat_line_start_count", ls_cnt, 5);
        check("repeat_queue_empty", exp_q.size(), 0);
`else
        for (int v = 0; v < 5; v++) begin
            setup(vecs[v].n, vecs[v].ys, vecs[v].st, vecs[v].gap, vecs[v].len);
            clear_counts();
            chk_kill = 1'b1;
            fin_auto = 1'b1;
            push_lines(vecs[v].ys, vecs[v].st, vecs[v].n);
            pulse_start();
            if (vecs[v].n == 0) begin
                check("n0_frame_done", frame_done, 1);
                check("n0_busy", busy, 0);
            end else begin
                check("busy_after_start", busy, 1);
            end
            wait_idle("frame_timeout");
            check("line_start_count", ls_cnt, vecs[v].n);
            check("frame_done_count", fd_cnt, 1);
            check("aborted_count", ab_cnt, 0);
            check("final_y_dac", y_dac, vecs[v].exp_dac);
            check("final_line_index", line_index, vecs[v].exp_idx);
            check("queue_empty", exp_q.size(), 0);
            repeat (3) @(negedge clk);
        end

        // Start together with kill in IDLE is rejected.
        clear_counts();
        setup(2, 16'h2000, 16'h0001, 3, 3);
        @(negedge clk);
        start = 1'b1;
        kill  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b0;
        check("start_with_kill_busy", busy, 0);
        check("start_with_kill_valid", y_dac_valid, 0);

        // Kill during SETTLE of line 0, with a start while busy beforehand.
        clear_counts();
        setup(2, 16'h3000, 16'h0001, 10, 5);
        push_lines(16'h3000, 16'h0001, 1);
        pulse_start();
        check("settle_busy", busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("settle_kill_aborted", aborted, 1);
        check("settle_kill_busy", busy, 0);
        repeat (15) @(negedge clk);
        check("settle_kill_no_start", ls_cnt, 0);
        check("settle_kill_abort_count", ab_cnt, 1);
        check("settle_kill_queue", exp_q.size(), 0);

        // Kill three cycles into RUN of line 1 of a four-line frame.
        clear_counts();
        chk_kill = 1'b0;
        setup(4, 16'h0400, 16'h0040, 2, 20);
        push_lines(16'h0400, 16'h0040, 2);
        pulse_start();
        for (int i = 0; i < 3000 && ls_cnt < 2; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("run_kill_line_kill", line_kill, 1);
        wait_idle("run_kill_timeout");
        check("run_kill_aborted", ab_cnt, 1);
        check("run_kill_no_frame_done", fd_cnt, 0);
        check("run_kill_line_index", line_index, 1);
        check("run_kill_line_starts", ls_cnt, 2);
        check("run_kill_queue", exp_q.size(), 0);
        chk_kill = 1'b1;

        // Finished edge and kill together in WAIT_FIN of the last line: kill wins.
        clear_counts();
        fin_auto = 1'b0;
        setup(1, 16'h0777, 16'h0001, 1, 2);
        push_lines(16'h0777, 16'h0001, 1);
        pulse_start();
        for (int i = 0; i < 3000 && !line_kill; i++) @(negedge clk);
        check("wf_line_kill_seen", line_kill, 1);
        kill          = 1'b1;
        line_finished = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("wf_aborted", aborted, 1);
        check("wf_frame_done", frame_done, 0);
        check("wf_busy", busy, 0);
        repeat (2) @(negedge clk);
        line_finished = 1'b0;
        fin_auto = 1'b1;

        // Reset mid-frame drops everything with no pulses.
        clear_counts();
        setup(3, 16'h5000, 16'h0100, 2, 30);
        push_lines(16'h5000, 16'h0100, 1);
        pulse_start();
        for (int i = 0; i < 3000 && ls_cnt < 1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midreset_busy", busy, 0);
        check("midreset_y_dac", y_dac, 0);
        check("midreset_line_index", line_index, 0);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        check("midreset_no_frame_done", fd_cnt, 0);
        check("midreset_no_aborted", ab_cnt, 0);
        check("midreset_queue", exp_q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/oct_line_sequencer.md
Name: oct_line_sequencer

Overview:
Frame-level (Y / slow-axis) scan sequencer that sits directly upstream of the CCD line trigger generator.
- For each of N B-scan lines it:
  - steps the slow-axis galvo DAC code;
  - waits a settle gap;
  - launches one line via a single-cycle start pulse (to the generator's data_rdy);
  - ends the line by pulsing a kill (to KILL_PROCESS) after a programmed line length;
  - waits for the generator's finished handshake.
- Reports frame completion or abort to the host-side control logic.

Parameters:
DAC_W, 16, width of slow-axis galvo DAC code
CNT_W, 32, width of settle and line-length cycle counters

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle frame start request; ignored while busy
kill  in  1  abort request; level or pulse, sampled every cycle
ydata_points_number  in  16  lines per frame (N)
y_start  in  DAC_W  DAC code of line 0
y_step  in  DAC_W  DAC code increment per line (two's-complement add, wraps)
line_gap_cycles  in  CNT_W  galvo settle cycles before each line
line_length_cycles  in  CNT_W  cycles from line_start to line_kill
line_finished  in  1  finished from the CCD line generator
line_start  out  1  one-cycle pulse to the generator's data_rdy
line_kill  out  1  one-cycle pulse to the generator's KILL_PROCESS
y_dac  out  DAC_W  current slow-axis DAC code
y_dac_valid  out  1  one-cycle strobe when y_dac changes
line_index  out  16  index of current line, 0..N-1
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse when all N lines have completed
aborted  out  1  one-cycle pulse when a frame ends due to kill

Behaviour:
- Reset (rstn low, async): state=IDLE. All outputs 0, y_dac=0. Counters cleared. finished-edge register cleared. Reset mid-frame abandons the frame silently, with no pulses.
- Every output is driven from a register.
- line_finished is edge-detected: a rising edge means line complete. Level-high does not retrigger.
- Configuration inputs are sampled on start and held internally for the whole frame.

State machine:
- IDLE:
  - start=1 and N>0 → load y_dac=y_start, line_index=0, pulse y_dac_valid, go SETTLE. Latency: start at edge T gives busy=1 and y_dac_valid=1 at T+1.
  - start=1 and N=0 → frame_done pulse next cycle, stay IDLE. line_start is never issued.
- SETTLE:
  - Counter runs 0..line_gap_cycles, so the state lasts line_gap_cycles+1 cycles (gap=0 gives 1 cycle).
  - Then go LAUNCH.
- LAUNCH:
  - line_start=1 for exactly one cycle; clear line counter; go RUN.
- RUN:
  - Counter increments from 0.
  - When counter == line_length_cycles: line_kill=1 for one cycle, go WAIT_FIN. length=0 gives kill on the first RUN cycle.
- WAIT_FIN:
  - On rising edge of line_finished:
    - line_index == N-1 → frame_done pulse, go IDLE.
    - Otherwise → y_dac += y_step (mod 2^DAC_W), line_index += 1, pulse y_dac_valid, go SETTLE.
  - No timeout.
- kill=1:
  - In SETTLE or LAUNCH: go IDLE next cycle, pulse aborted. A line_start not yet issued is suppressed.
  - In RUN: issue line_kill immediately (one cycle), go WAIT_FIN with an abort flag set. On line_finished edge, pulse aborted (not frame_done) and go IDLE.
  - In WAIT_FIN: set abort flag; the completion edge then yields aborted. This also applies when it would have been the last line.
  - In IDLE: ignored. start in the same cycle as kill is rejected.
- Simultaneous line_finished edge and kill in WAIT_FIN: kill wins → aborted.
- line_finished edge outside WAIT_FIN: ignored. The edge register still updates.
- y_dac and line_index hold their last values in IDLE after a frame.

Optional Feature:
Macro FRAME_REPEAT_EN.
- Defined:
  - After the last line completes, pulse frame_done.
  - Reload y_dac=y_start, line_index=0, pulse y_dac_valid, go SETTLE.
  - Frames repeat until kill, which ends with aborted.
  - busy stays high between frames.
- Undefined: the frame ends in IDLE as described above.

Test Plan:
- N=3, y_start=0x1000, y_step=0x0100, gap=4, length=10; model line_finished rising 2 cycles after each line_kill → exactly 3 line_start pulses, each 5 cycles after its y_dac_valid; y_dac sequence 0x1000, 0x1100, 0x1200; one frame_done; busy low afterwards.
- N=0, start → frame_done one cycle later, no line_start, busy stays 0.
- y_start=0xFFF0, y_step=0x0020, N=2 → second y_dac=0x0010 (wrap).
- kill asserted 3 cycles into RUN of line 1 (N=4) → line_kill next cycle; after line_finished, aborted=1 and frame_done never pulses; line_index=1.
- kill during SETTLE of line 0 → no line_start, aborted pulse next cycle, IDLE; start during busy is ignored (no double launch).
- FRAME_REPEAT_EN, N=2 → line_start count = 2 per frame; frame_done every frame; kill in WAIT_FIN → aborted, IDLE.
